// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: decodes MIPS-style conditional branches, registers the outcome one
// cycle later and keeps resolved/mispredicted counts. Define BRANCH_PREDICT_EN to build the BHT.
module branch_resolve_unit #(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [5:0]        op,
    input  logic [4:0]        rt,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [31:0]       pc,
    output logic              out_valid,
    output logic              is_branch,
    output logic              taken,
    output logic              pred_taken,
    output logic              mispredict,
    output logic [31:0]       br_count,
    output logic [31:0]       mp_count
);

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    // ------------------------------------------------------------------
    // Decode and condition evaluation
    // ------------------------------------------------------------------
    logic a_neg;
    logic a_zero;
    logic a_eq_b;
    logic dec_is_branch;
    logic dec_taken;

    assign a_neg  = a[DATA_W-1];
    assign a_zero = (a == '0);
    assign a_eq_b = (a == b);

    always_comb begin
        dec_is_branch = 1'b0;
        dec_taken     = 1'b0;
        case (op)
            OP_BEQ: begin
                dec_is_branch = 1'b1;
                dec_taken     = a_eq_b;
            end
            OP_BNE: begin
                dec_is_branch = 1'b1;
                dec_taken     = ~a_eq_b;
            end
            OP_BGTZ: begin
                dec_is_branch = 1'b1;
                dec_taken     = ~a_neg & ~a_zero;
            end
            OP_BLEZ: begin
                dec_is_branch = 1'b1;
                dec_taken     = a_neg | a_zero;
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BGEZ, RT_BGEZAL: begin
                        dec_is_branch = 1'b1;
                        dec_taken     = ~a_neg;
                    end
                    RT_BLTZ, RT_BLTZAL: begin
                        dec_is_branch = 1'b1;
                        dec_taken     = a_neg;
                    end
                    default: begin
                        dec_is_branch = 1'b0;
                        dec_taken     = 1'b0;
                    end
                endcase
            end
            default: begin
                dec_is_branch = 1'b0;
                dec_taken     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic        capture;
    logic        resolve;
    logic        valid_q, valid_d;
    logic        is_branch_q, is_branch_d;
    logic        taken_q, taken_d;
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] mp_count_q, mp_count_d;

    // A resident branch retires whenever the stage is not stalled, even if the
    // instruction arriving behind it is being flushed.
    assign capture = in_valid & ~stall & ~flush;
    assign resolve = valid_q & is_branch_q & ~stall;

    always_comb begin
        valid_d     = valid_q;
        is_branch_d = is_branch_q;
        taken_d     = taken_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
            if (in_valid) begin
                is_branch_d = dec_is_branch;
                taken_d     = dec_taken;
            end
        end
    end

    always_comb begin
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (resolve) begin
            br_count_d = br_count_q + 32'd1;
            if (mispredict) begin
                mp_count_d = mp_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            is_branch_q <= 1'b0;
            taken_q     <= 1'b0;
            br_count_q  <= 32'd0;
            mp_count_q  <= 32'd0;
        end else begin
            valid_q     <= valid_d;
            is_branch_q <= is_branch_d;
            taken_q     <= taken_d;
            br_count_q  <= br_count_d;
            mp_count_q  <= mp_count_d;
        end
    end

    assign out_valid = valid_q;
    assign is_branch = is_branch_q;
    assign taken     = taken_q;
    assign br_count  = br_count_q;
    assign mp_count  = mp_count_q;

    logic unused_pc;
    assign unused_pc = ^pc;

`ifdef BRANCH_PREDICT_EN
    // ------------------------------------------------------------------
    // Branch history table of 2-bit saturating counters
    // ------------------------------------------------------------------
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [IDX_W-1:0] idx_c;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pred_q, pred_d;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_upd;

    assign idx_c = pc[IDX_W+1:2];

    // The table read sees the value before this cycle's write, so a same-index
    // capture and update yields the pre-update prediction.
    always_comb begin
        idx_d  = idx_q;
        pred_d = pred_q;
        if (capture) begin
            idx_d  = idx_c;
            pred_d = bht_q[idx_c][1];
        end
    end

    always_comb begin
        ctr_cur = bht_q[idx_q];
        ctr_upd = ctr_cur;
        if (taken_q) begin
            if (ctr_cur != 2'b11) begin
                ctr_upd = ctr_cur + 2'b01;
            end
        end else if (ctr_cur != 2'b00) begin
            ctr_upd = ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            pred_q <= 1'b0;
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            idx_q  <= idx_d;
            pred_q <= pred_d;
            if (resolve) begin
                bht_q[idx_q] <= ctr_upd;
            end
        end
    end

    assign pred_taken = pred_q;
    assign mispredict = valid_q & is_branch_q & (taken_q ^ pred_q);
`else
    logic unused_capture;
    assign unused_capture = capture;

    // Static not-taken prediction: every taken branch counts as a mispredict.
    assign pred_taken = 1'b0;
    assign mispredict = valid_q & is_branch_q & taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised scoreboard bench for branch_resolve_unit; the reference model follows the
// BRANCH_PREDICT_EN setting of the build.
`timescale 1ns/1ps
module tb_branch_resolve_unit;

    localparam int DATA_W    = 32;
    localparam int BHT_DEPTH = 16;
    localparam int REC_W     = 68;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [5:0]        op;
    logic [4:0]        rt;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [31:0]       pc;
    logic              out_valid;
    logic              is_branch;
    logic              taken;
    logic              pred_taken;
    logic              mispredict;
    logic [31:0]       br_count;
    logic [31:0]       mp_count;

    branch_resolve_unit #(.DATA_W(DATA_W), .BHT_DEPTH(BHT_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .op        (op),
        .rt        (rt),
        .a         (a),
        .b         (b),
        .pc        (pc),
        .out_valid (out_valid),
        .is_branch (is_branch),
        .taken     (taken),
        .pred_taken(pred_taken),
        .mispredict(mispredict),
        .br_count  (br_count),
        .mp_count  (mp_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    // record: {is_branch, taken, pred_taken, mispredict, br_count, mp_count}
    logic [REC_W-1:0] exp_q[$];

    // reference model
    logic [31:0] m_br;
    logic [31:0] m_mp;
    bit          m_res_v;
    bit          m_res_br;
    bit          m_res_mis;
`ifdef BRANCH_PREDICT_EN
    bit          m_res_tk;
    int          m_res_idx;
    int          m_ctr[BHT_DEPTH];
`endif

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Branch rules written as signed comparisons on the operands.
    function automatic void ref_decode(input logic [5:0] o, input logic [4:0] t,
                                       input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                       output bit isbr, output bit tk);
        isbr = 1'b1;
        tk   = 1'b0;
        case (o)
            6'd4: tk = (x == y);
            6'd5: tk = (x != y);
            6'd7: tk = ($signed(x) > 0);
            6'd6: tk = ($signed(x) <= 0);
            6'd1: begin
                if (t == 5'd1 || t == 5'd17) tk = ($signed(x) >= 0);
                else if (t == 5'd0 || t == 5'd16) tk = ($signed(x) < 0);
                else isbr = 1'b0;
            end
            default: isbr = 1'b0;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit v, input bit st, input bit fl,
                        input logic [5:0] o, input logic [4:0] t,
                        input logic [31:0] x, input logic [31:0] y, input logic [31:0] pp);
        bit isbr;
        bit tk;
        bit pred;
        bit mis;
`ifdef BRANCH_PREDICT_EN
        int idx;
`endif
        @(posedge clk);
        #1;
        rst = r; in_valid = v; stall = st; flush = fl;
        op = o; rt = t; a = x; b = y; pc = pp;
        if (r) begin
            m_br = 0; m_mp = 0; m_res_v = 0;
`ifdef BRANCH_PREDICT_EN
            for (int i = 0; i < BHT_DEPTH; i++) m_ctr[i] = 1;
`endif
        end else begin
            pred = 1'b0;
`ifdef BRANCH_PREDICT_EN
            idx  = int'((pp >> 2) % BHT_DEPTH);
            pred = (m_ctr[idx] >= 2);
`endif
            if (m_res_v && !st && m_res_br) begin
                m_br = m_br + 1;
                if (m_res_mis) m_mp = m_mp + 1;
`ifdef BRANCH_PREDICT_EN
                if (m_res_tk) m_ctr[m_res_idx] = (m_ctr[m_res_idx] == 3) ? 3 : m_ctr[m_res_idx] + 1;
                else          m_ctr[m_res_idx] = (m_ctr[m_res_idx] == 0) ? 0 : m_ctr[m_res_idx] - 1;
`endif
            end
            if (fl) begin
                m_res_v = 0;
            end else if (!st) begin
                m_res_v = v;
                if (v) begin
                    ref_decode(o, t, x, y, isbr, tk);
                    mis = isbr && (tk != pred);
                    m_res_br  = isbr;
                    m_res_mis = mis;
`ifdef BRANCH_PREDICT_EN
                    m_res_tk  = tk;
                    m_res_idx = idx;
`endif
                    exp_q.push_back({isbr, tk, pred, mis, m_br, m_mp});
                end
            end
        end
    endtask

    task automatic step_idle();
        step(0, 0, 0, 0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic issue(input logic [5:0] o, input logic [4:0] t,
                         input logic [31:0] x, input logic [31:0] y, input logic [31:0] pp);
        step(0, 1, 0, 0, o, t, x, y, pp);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
        chk({tag, "_is_branch"},  32'(is_branch),  32'd0);
        chk({tag, "_taken"},      32'(taken),      32'd0);
        chk({tag, "_pred_taken"}, 32'(pred_taken), 32'd0);
        chk({tag, "_mispredict"}, 32'(mispredict), 32'd0);
        chk({tag, "_br_count"},   br_count,        32'd0);
        chk({tag, "_mp_count"},   mp_count,        32'd0);
    endtask

    // ---------------- monitor ----------------
    // Compares the resident result every cycle it is visible; the entry is retired
    // once the stage lets it go (not stalled, flushed under stall, or reset).
    always @(negedge clk) begin : monitor
        logic [REC_W-1:0] e;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: out_valid=1 with no expected entry at %0t", $time);
            end else begin
                e = exp_q[0];
                chk("is_branch",  32'(is_branch),  32'(e[67]));
                chk("taken",      32'(taken),      32'(e[66]));
                chk("pred_taken", 32'(pred_taken), 32'(e[65]));
                chk("mispredict", 32'(mispredict), 32'(e[64]));
                chk("br_count",   br_count,        e[63:32]);
                chk("mp_count",   mp_count,        e[31:0]);
                if (rst || flush || !stall) void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        logic [5:0]  ops [10];
        logic [4:0]  rts [5];
        logic [31:0] x;
        logic [31:0] y;
        ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd1, 6'd0, 6'd35, 6'd2};
        rts = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd3};
        rst = 1; in_valid = 0; stall = 0; flush = 0;
        op = 0; rt = 0; a = 0; b = 0; pc = 0;
        m_br = 0; m_mp = 0; m_res_v = 0; m_res_br = 0; m_res_mis = 0;

        step(1, 0, 0, 0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step(1, 0, 0, 0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step_idle();
        check_zero("reset");

        // decode basics
        issue(6'b000100, 5'd0, 32'h1234, 32'h1234, 32'h100);
        issue(6'b000101, 5'd0, 32'h1234, 32'h1234, 32'h100);
        // sign edges
        issue(6'b000001, 5'b00000, 32'h8000_0000, 32'd0, 32'h104);
        issue(6'b000111, 5'd0, 32'd0, 32'd0, 32'h108);
        issue(6'b000110, 5'd0, 32'd0, 32'd0, 32'h10C);
        issue(6'b000001, 5'b00011, 32'd5, 32'd0, 32'h110);
        issue(6'b000001, 5'b10001, 32'h8000_0000, 32'd0, 32'h114);
        issue(6'b000001, 5'b10000, 32'hFFFF_FFFF, 32'd0, 32'h118);
        issue(6'b000111, 5'd0, 32'h7FFF_FFFF, 32'd0, 32'h11C);
        step_idle();
        step_idle();

        // predictor training: four taken beqs on one index
        step(1, 0, 0, 0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) issue(6'b000100, 5'd0, 32'd7, 32'd7, 32'h40);
        step_idle();
        step_idle();
        chk("train_br_count", br_count, 32'd4);
`ifdef BRANCH_PREDICT_EN
        chk("train_mp_count", mp_count, 32'd2);
`else
        chk("train_mp_count", mp_count, 32'd4);
`endif

        // stall hold, then flush
        issue(6'b000101, 5'd0, 32'd1, 32'd2, 32'h80);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 6'b000100, 5'd0, 32'd3, 32'd3, 32'h84);
        step(0, 1, 0, 1, 6'b000100, 5'd0, 32'd3, 32'd3, 32'h84);
        step_idle();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_br_count", br_count, m_br);
        // flush while stalled discards the resident branch
        issue(6'b000100, 5'd0, 32'd9, 32'd9, 32'h88);
        step(0, 1, 1, 1, 6'b000100, 5'd0, 32'd9, 32'd9, 32'h88);
        step_idle();
        chk("stall_flush_out_valid", 32'(out_valid), 32'd0);
        chk("stall_flush_br_count", br_count, m_br);

        // reset with a taken branch in flight
        issue(6'b000100, 5'd0, 32'd1, 32'd1, 32'h40);
        step(1, 1, 0, 0, 6'b000100, 5'd0, 32'd1, 32'd1, 32'h40);
        step_idle();
        check_zero("midreset");
        issue(6'b000100, 5'd0, 32'd1, 32'd1, 32'h40);
        step_idle();
        chk("post_reset_pred", 32'(pred_taken), 32'd0);
        step_idle();

        // counter wrap
        step_idle();
        force dut.br_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_count_q;
        m_br = 32'hFFFF_FFFF;
        issue(6'b000100, 5'd0, 32'h55, 32'h55, 32'h10);
        step_idle();
        chk("wrap_out_valid", 32'(out_valid), 32'd1);
`ifndef BRANCH_PREDICT_EN
        chk("nopred_pred_taken", 32'(pred_taken), 32'd0);
        chk("nopred_mispredict", 32'(mispredict), 32'd1);
`endif
        step_idle();
        chk("wrap_br_count", br_count, 32'd0);

        // randomised traffic
        for (int n = 0; n < 600; n++) begin
            x = pick_val();
            y = ($urandom_range(0, 2) == 0) ? x : pick_val();
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0),
                 ops[$urandom_range(0, 9)], rts[$urandom_range(0, 4)], x, y,
                 ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 31)) << 2));
        end

        step_idle();
        step_idle();
        step_idle();
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_br_count", br_count, m_br);
        chk("final_mp_count", mp_count, m_mp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
